exu_alu_wb_buf: RTL and testbench

- Registered writeback buffer directly downstream of the ALU execute unit.
- Captures the ALU's combinational result, write enable and destination register each cycle into a small in-order FIFO.
- Presents one writeback request at a time to the register-file writeback arbiter, which may withhold the port for higher-priority units (LSU, MDU).
- Provides forwarding lookup of pending entries and an almost-full stall so the issue stage throttles before overflow.

---
 rtl/exu_alu_wb_buf_pkg.sv | 24 ++
 rtl/exu_alu_wb_buf_if.sv | 44 ++++
 rtl/exu_alu_wb_buf_fwd_match.sv | 30 +++
 rtl/exu_alu_wb_buf.sv | 99 +++++++++
 tb/tb_exu_alu_wb_buf.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/exu_alu_wb_buf_pkg.sv
// Shared widths, defaults and the entry type for the ALU writeback buffer.
package exu_alu_wb_buf_pkg;

  localparam int REG_ADDR_WIDTH   = 5;
  localparam int REG_DATA_WIDTH   = 32;
  localparam int ALU_WB_BUF_DEPTH = 4;

  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [REG_DATA_WIDTH-1:0] reg_data_t;

  typedef struct packed {
    reg_addr_t waddr;
    reg_data_t wdata;
  } wb_entry_t;

  // x0 is hardwired to zero, so writes to it never need to reach the register file.
  function automatic logic is_wb_push(input logic we, input reg_addr_t waddr);
    return (we == WRITE_ENABLE) && (waddr != '0);
  endfunction

endpackage

// File: rtl/exu_alu_wb_buf_if.sv
// Bundle of ALU capture, writeback handshake, forwarding and status signals.
interface exu_alu_wb_buf_if;
  import exu_alu_wb_buf_pkg::*;

  logic      alu_reg_we_i;
  reg_addr_t alu_reg_waddr_i;
  reg_data_t alu_result_i;

  logic      wb_req_o;
  reg_addr_t wb_waddr_o;
  reg_data_t wb_wdata_o;
  logic      wb_ready_i;

  reg_addr_t fwd_raddr1_i;
  reg_addr_t fwd_raddr2_i;
  logic      fwd_hit1_o;
  logic      fwd_hit2_o;
  reg_data_t fwd_data1_o;
  reg_data_t fwd_data2_o;

  logic      alu_stall_o;
  logic      overflow_o;

  // Buffer side.
  modport slave (
    input  alu_reg_we_i, alu_reg_waddr_i, alu_result_i,
    input  wb_ready_i,
    input  fwd_raddr1_i, fwd_raddr2_i,
    output wb_req_o, wb_waddr_o, wb_wdata_o,
    output fwd_hit1_o, fwd_hit2_o, fwd_data1_o, fwd_data2_o,
    output alu_stall_o, overflow_o
  );

  // ALU / arbiter / issue-stage side.
  modport master (
    output alu_reg_we_i, alu_reg_waddr_i, alu_result_i,
    output wb_ready_i,
    output fwd_raddr1_i, fwd_raddr2_i,
    input  wb_req_o, wb_waddr_o, wb_wdata_o,
    input  fwd_hit1_o, fwd_hit2_o, fwd_data1_o, fwd_data2_o,
    input  alu_stall_o, overflow_o
  );

endinterface

// File: rtl/exu_alu_wb_buf_fwd_match.sv
// Youngest-match lookup of one source register over the pending buffer entries.
module alu_wb_fwd_match
  import exu_alu_wb_buf_pkg::*;
#(
  parameter  int DEPTH = ALU_WB_BUF_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  wb_entry_t        entries [DEPTH],
  input  logic [PTR_W-1:0] rd_ptr,
  input  logic [CNT_W-1:0] count,
  input  reg_addr_t        raddr,
  output logic             hit,
  output reg_data_t        data
);

  // Walk oldest to youngest; a later match overrides, so the youngest wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count) && (raddr != '0) &&
          (entries[rd_ptr + PTR_W'(i)].waddr == raddr)) begin
        hit  = 1'b1;
        data = entries[rd_ptr + PTR_W'(i)].wdata;
      end
    end
  end

endmodule

// File: rtl/exu_alu_wb_buf.sv
// In-order writeback FIFO between the ALU and the register-file writeback arbiter.
module exu_alu_wb_buf
  import exu_alu_wb_buf_pkg::*;
#(
  parameter  int DEPTH = ALU_WB_BUF_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  exu_alu_wb_buf_if.slave  bus
);

  localparam int               CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_STALL = CNT_W'(DEPTH - 1);

  wb_entry_t        entries [DEPTH];
  wb_entry_t        head;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;

  logic push_req;
  logic pop;
  logic full;
  logic push_ok;
  logic drop;

  // Handshake decode; a pop frees a slot in the same cycle so a full buffer can still accept.
  always_comb begin
    push_req = is_wb_push(bus.alu_reg_we_i, bus.alu_reg_waddr_i);
    full     = (count == CNT_FULL);
    pop      = (count != '0) && bus.wb_ready_i;
    push_ok  = push_req && (!full || pop);
    drop     = push_req && full && !pop;
  end

  // Pointers, occupancy and the sticky overflow flag; validity lives only here.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Entry storage is not reset; stale slots are masked by count and pointers.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      entries[wr_ptr] <= '{waddr: bus.alu_reg_waddr_i, wdata: bus.alu_result_i};
    end
  end

  // Head presentation is purely from registered state, so it holds while the arbiter withholds the port.
  always_comb begin
    head            = entries[rd_ptr];
    bus.wb_req_o    = (count != '0);
    bus.wb_waddr_o  = bus.wb_req_o ? head.waddr : '0;
    bus.wb_wdata_o  = bus.wb_req_o ? head.wdata : '0;
    bus.alu_stall_o = (count >= CNT_STALL);
    bus.overflow_o  = overflow;
  end

  alu_wb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
    .entries (entries),
    .rd_ptr  (rd_ptr),
    .count   (count),
    .raddr   (bus.fwd_raddr1_i),
    .hit     (bus.fwd_hit1_o),
    .data    (bus.fwd_data1_o)
  );

  alu_wb_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
    .entries (entries),
    .rd_ptr  (rd_ptr),
    .count   (count),
    .raddr   (bus.fwd_raddr2_i),
    .hit     (bus.fwd_hit2_o),
    .data    (bus.fwd_data2_o)
  );

endmodule

// File: tb/tb_exu_alu_wb_buf.sv
// Directed self-checking bench for exu_alu_wb_buf (DEPTH = 4).
module tb_exu_alu_wb_buf;
  import exu_alu_wb_buf_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  logic [4:0]  pp_addr [4];
  logic [31:0] pp_data [4];

  exu_alu_wb_buf_if bus ();

  exu_alu_wb_buf #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_push(input logic [4:0] addr, input logic [31:0] data);
    bus.alu_reg_we_i    = WRITE_ENABLE;
    bus.alu_reg_waddr_i = addr;
    bus.alu_result_i    = data;
  endtask

  initial begin
    rst                 = 1'b1;
    bus.alu_reg_we_i    = WRITE_DISABLE;
    bus.alu_reg_waddr_i = '0;
    bus.alu_result_i    = '0;
    bus.wb_ready_i      = 1'b0;
    bus.fwd_raddr1_i    = '0;
    bus.fwd_raddr2_i    = '0;
    pp_addr = '{5'd2, 5'd3, 5'd4, 5'd6};
    pp_data = '{32'hA2, 32'hA3, 32'hA4, 32'hB6};
    tick();
    tick();
    rst = 1'b0;

    // reset state
    chk("reset_req",   32'(bus.wb_req_o),    32'd0);
    chk("reset_waddr", 32'(bus.wb_waddr_o),  32'd0);
    chk("reset_wdata", bus.wb_wdata_o,       32'd0);
    chk("reset_stall", 32'(bus.alu_stall_o), 32'd0);
    chk("reset_ovf",   32'(bus.overflow_o),  32'd0);
    chk("reset_hit1",  32'(bus.fwd_hit1_o),  32'd0);
    chk("reset_data1", bus.fwd_data1_o,      32'd0);

    // single push, one-cycle latency, then pop
    drive_push(5'd5, 32'h1234);
    bus.fwd_raddr1_i = 5'd5;
    chk("push_cycle_req", 32'(bus.wb_req_o),   32'd0);
    chk("push_cycle_hit", 32'(bus.fwd_hit1_o), 32'd0);
    tick();
    bus.alu_reg_we_i = WRITE_DISABLE;
    chk("single_req",   32'(bus.wb_req_o),   32'd1);
    chk("single_waddr", 32'(bus.wb_waddr_o), 32'd5);
    chk("single_wdata", bus.wb_wdata_o,      32'h1234);
    chk("single_hit1",  32'(bus.fwd_hit1_o), 32'd1);
    chk("single_data1", bus.fwd_data1_o,     32'h1234);
    bus.wb_ready_i = 1'b1;
    chk("pop_cycle_hit1", 32'(bus.fwd_hit1_o), 32'd1);
    tick();
    bus.wb_ready_i = 1'b0;
    chk("after_pop_req",   32'(bus.wb_req_o),   32'd0);
    chk("after_pop_wdata", bus.wb_wdata_o,      32'd0);
    chk("after_pop_hit1",  32'(bus.fwd_hit1_o), 32'd0);

    // write to x0 is discarded
    drive_push(5'd0, 32'hFFFF_FFFF);
    bus.fwd_raddr1_i = 5'd0;
    tick();
    bus.alu_reg_we_i = WRITE_DISABLE;
    chk("x0_req",   32'(bus.wb_req_o),    32'd0);
    chk("x0_stall", 32'(bus.alu_stall_o), 32'd0);
    chk("x0_hit1",  32'(bus.fwd_hit1_o),  32'd0);
    chk("x0_data1", bus.fwd_data1_o,      32'd0);

    // fill with the arbiter withholding the port; stall from count 3
    bus.fwd_raddr2_i = 5'd9;
    for (int k = 1; k <= 4; k++) begin
      drive_push(5'(k), 32'(k * 17));
      tick();
      chk("fill_stall", 32'(bus.alu_stall_o), (k >= 3) ? 32'd1 : 32'd0);
      chk("fill_head_hold", 32'(bus.wb_waddr_o), 32'd1);
    end
    drive_push(5'd9, 32'h99);
    chk("full_pre_ovf", 32'(bus.overflow_o), 32'd0);
    tick();
    bus.alu_reg_we_i = WRITE_DISABLE;
    chk("full_ovf",       32'(bus.overflow_o), 32'd1);
    chk("full_head_hold", 32'(bus.wb_wdata_o), 32'h11);
    chk("full_drop_hit2", 32'(bus.fwd_hit2_o), 32'd0);
    bus.wb_ready_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("drain_waddr", 32'(bus.wb_waddr_o), 32'(k));
      chk("drain_wdata", bus.wb_wdata_o,      32'(k * 17));
      tick();
    end
    bus.wb_ready_i = 1'b0;
    chk("drain_empty_req", 32'(bus.wb_req_o),   32'd0);
    chk("ovf_sticky",      32'(bus.overflow_o), 32'd1);

    // reset clears overflow; push and pop together while full
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ovf_cleared", 32'(bus.overflow_o), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      drive_push(5'(k), 32'(32'hA0 + k));
      tick();
    end
    drive_push(5'd6, 32'hB6);
    bus.wb_ready_i = 1'b1;
    tick();
    bus.alu_reg_we_i = WRITE_DISABLE;
    bus.wb_ready_i   = 1'b0;
    chk("pp_ovf",   32'(bus.overflow_o),  32'd0);
    chk("pp_stall", 32'(bus.alu_stall_o), 32'd1);
    chk("pp_head",  32'(bus.wb_waddr_o),  32'd2);
    bus.wb_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("pp_drain_waddr", 32'(bus.wb_waddr_o), 32'(pp_addr[k]));
      chk("pp_drain_wdata", bus.wb_wdata_o,      pp_data[k]);
      tick();
    end
    bus.wb_ready_i = 1'b0;
    chk("pp_empty_req", 32'(bus.wb_req_o), 32'd0);

    // youngest match wins
    drive_push(5'd7, 32'hA);
    tick();
    drive_push(5'd7, 32'hB);
    tick();
    bus.alu_reg_we_i = WRITE_DISABLE;
    bus.fwd_raddr1_i = 5'd7;
    bus.fwd_raddr2_i = 5'd8;
    #1;
    chk("fwd_hit1",  32'(bus.fwd_hit1_o), 32'd1);
    chk("fwd_data1", bus.fwd_data1_o,     32'hB);
    chk("fwd_hit2",  32'(bus.fwd_hit2_o), 32'd0);
    chk("fwd_data2", bus.fwd_data2_o,     32'd0);
    chk("fwd_head_wdata", bus.wb_wdata_o, 32'hA);

    // reset mid-operation with a push in the reset cycle
    drive_push(5'd3, 32'h33);
    tick();
    chk("pre_rst_stall", 32'(bus.alu_stall_o), 32'd1);
    rst = 1'b1;
    drive_push(5'd6, 32'h66);
    bus.fwd_raddr2_i = 5'd6;
    tick();
    rst = 1'b0;
    bus.alu_reg_we_i = WRITE_DISABLE;
    chk("rst_req",   32'(bus.wb_req_o),    32'd0);
    chk("rst_wdata", bus.wb_wdata_o,       32'd0);
    chk("rst_stall", 32'(bus.alu_stall_o), 32'd0);
    chk("rst_ovf",   32'(bus.overflow_o),  32'd0);
    chk("rst_hit1",  32'(bus.fwd_hit1_o),  32'd0);
    chk("rst_hit2",  32'(bus.fwd_hit2_o),  32'd0);
    tick();
    chk("rst_req_late", 32'(bus.wb_req_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
